// File: rtl/seq_det_scan_ctrl_if.sv
// Word-in / result-out handshake bundle plus serial hookup to the external "10101" detector.
// Defining SCAN_OVF_FLAG_EN adds the out_ovf result flag.
interface seq_det_scan_ctrl_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned IDX_W = $clog2(WORD_W);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic              out_hit;
  logic [CNT_W-1:0]  out_count;
  logic [IDX_W-1:0]  out_first;
`ifdef SCAN_OVF_FLAG_EN
  logic              out_ovf;
`endif
  logic              det_d_in;
  logic              det_reset_n;
  logic              det_q_out;

  // Controller side
  modport master (
`ifdef SCAN_OVF_FLAG_EN
    output out_ovf,
`endif
    input  in_valid, in_word, out_ready, det_q_out,
    output in_ready, out_valid, out_hit, out_count, out_first, det_d_in, det_reset_n
  );

  // Word source, result sink and detector side
  modport slave (
`ifdef SCAN_OVF_FLAG_EN
    input  out_ovf,
`endif
    output in_valid, in_word, out_ready, det_q_out,
    input  in_ready, out_valid, out_hit, out_count, out_first, det_d_in, det_reset_n
  );
endinterface

// File: rtl/seq_det_scan_ctrl.sv
// Serialises words MSB-first into an external Mealy "10101" detector and returns per-word results.
// Optional feature macro: SCAN_OVF_FLAG_EN (adds out_ovf, set when the match count saturated).
module seq_det_scan_ctrl #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input logic                 clk,
  input logic                 reset,
  seq_det_scan_ctrl_if.master bus
);
  localparam int unsigned      IDX_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  logic [WORD_W-2:0] shreg;
  logic [IDX_W-1:0]  bit_idx;

  logic              run_hit;
  logic [CNT_W-1:0]  run_cnt;
  logic [IDX_W-1:0]  run_first;
  logic              pend_hit;
  logic [CNT_W-1:0]  pend_cnt;
  logic [IDX_W-1:0]  pend_first;
  logic              tally_hit;
  logic [CNT_W-1:0]  tally_cnt;
  logic [IDX_W-1:0]  tally_first;
`ifdef SCAN_OVF_FLAG_EN
  logic              run_ovf;
  logic              pend_ovf;
  logic              tally_ovf;
`endif

  logic last_bit;
  logic slot_free;
  logic in_ready_c;
  logic accept;

  always_comb begin
    last_bit   = (state == SHIFT) && (bit_idx == IDX_LAST);
    slot_free  = !bus.out_valid || bus.out_ready;
    in_ready_c = (state == IDLE) || (last_bit && slot_free);
    accept     = bus.in_valid && in_ready_c;
  end

  assign bus.in_ready = in_ready_c;

  // Running tally including the detector's verdict on the bit currently on the wire.
  always_comb begin
    tally_hit   = run_hit | bus.det_q_out;
    tally_cnt   = run_cnt;
    tally_first = run_first;
`ifdef SCAN_OVF_FLAG_EN
    tally_ovf   = run_ovf;
`endif
    if (bus.det_q_out) begin
      if (run_cnt == CNT_MAX) begin
`ifdef SCAN_OVF_FLAG_EN
        tally_ovf = 1'b1;
`endif
      end else begin
        tally_cnt = run_cnt + CNT_W'(1);
      end
      if (!run_hit) tally_first = bit_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      shreg           <= '0;
      bit_idx         <= '0;
      run_hit         <= 1'b0;
      run_cnt         <= '0;
      run_first       <= '0;
      pend_hit        <= 1'b0;
      pend_cnt        <= '0;
      pend_first      <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_hit     <= 1'b0;
      bus.out_count   <= '0;
      bus.out_first   <= '0;
      bus.det_d_in    <= 1'b0;
      bus.det_reset_n <= 1'b0;
`ifdef SCAN_OVF_FLAG_EN
      run_ovf         <= 1'b0;
      pend_ovf        <= 1'b0;
      bus.out_ovf     <= 1'b0;
`endif
    end else begin
      if (bus.out_ready) bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state           <= SHIFT;
            shreg           <= bus.in_word[WORD_W-2:0];
            bus.det_d_in    <= bus.in_word[WORD_W-1];
            bus.det_reset_n <= 1'b1;
            bit_idx         <= '0;
            run_hit         <= 1'b0;
            run_cnt         <= '0;
            run_first       <= '0;
`ifdef SCAN_OVF_FLAG_EN
            run_ovf         <= 1'b0;
`endif
          end else begin
            bus.det_d_in    <= 1'b0;
            bus.det_reset_n <= 1'b0;
          end
        end

        SHIFT: begin
          if (!last_bit) begin
            bit_idx         <= bit_idx + IDX_W'(1);
            shreg           <= shreg << 1;
            bus.det_d_in    <= shreg[WORD_W-2];
            bus.det_reset_n <= 1'b1;
            run_hit         <= tally_hit;
            run_cnt         <= tally_cnt;
            run_first       <= tally_first;
`ifdef SCAN_OVF_FLAG_EN
            run_ovf         <= tally_ovf;
`endif
          end else if (slot_free) begin
            bus.out_valid <= 1'b1;
            bus.out_hit   <= tally_hit;
            bus.out_count <= tally_cnt;
            bus.out_first <= tally_first;
`ifdef SCAN_OVF_FLAG_EN
            bus.out_ovf   <= tally_ovf;
`endif
            // Back-to-back word keeps the detector running so matches can straddle words.
            if (accept) begin
              shreg           <= bus.in_word[WORD_W-2:0];
              bus.det_d_in    <= bus.in_word[WORD_W-1];
              bus.det_reset_n <= 1'b1;
              bit_idx         <= '0;
              run_hit         <= 1'b0;
              run_cnt         <= '0;
              run_first       <= '0;
`ifdef SCAN_OVF_FLAG_EN
              run_ovf         <= 1'b0;
`endif
            end else begin
              state           <= IDLE;
              bus.det_d_in    <= 1'b0;
              bus.det_reset_n <= 1'b0;
            end
          end else begin
            state           <= WAIT;
            pend_hit        <= tally_hit;
            pend_cnt        <= tally_cnt;
            pend_first      <= tally_first;
`ifdef SCAN_OVF_FLAG_EN
            pend_ovf        <= tally_ovf;
`endif
            bus.det_d_in    <= 1'b0;
            bus.det_reset_n <= 1'b0;
          end
        end

        WAIT: begin
          bus.det_d_in    <= 1'b0;
          bus.det_reset_n <= 1'b0;
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b1;
            bus.out_hit   <= pend_hit;
            bus.out_count <= pend_cnt;
            bus.out_first <= pend_first;
`ifdef SCAN_OVF_FLAG_EN
            bus.out_ovf   <= pend_ovf;
`endif
          end
        end

        default: begin
          state           <= IDLE;
          bus.det_d_in    <= 1'b0;
          bus.det_reset_n <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_det_scan_ctrl.sv
// Bench for seq_det_scan_ctrl: directed cases plus random traffic against a bit-stream reference model.
// Two instances (CNT_W=8 and CNT_W=2) share stimulus so count saturation is exercised.
module tb_seq_det_scan_ctrl;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_HI = 8;
  localparam int unsigned CNT_LO = 2;
  localparam int          MAX_HI = 255;
  localparam int          MAX_LO = 3;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              rst_req   = 1'b1;
  logic              in_valid  = 1'b0;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] in_word   = '0;

  always #5 clk = ~clk;

  seq_det_scan_ctrl_if #(.WORD_W(WORD_W), .CNT_W(CNT_HI)) bus_hi ();
  seq_det_scan_ctrl_if #(.WORD_W(WORD_W), .CNT_W(CNT_LO)) bus_lo ();

  seq_det_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_HI)) dut     (.clk(clk), .reset(reset), .bus(bus_hi));
  seq_det_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_LO)) dut_sat (.clk(clk), .reset(reset), .bus(bus_lo));

  assign bus_hi.in_valid  = in_valid;
  assign bus_hi.in_word   = in_word;
  assign bus_hi.out_ready = out_ready;
  assign bus_lo.in_valid  = in_valid;
  assign bus_lo.in_word   = in_word;
  assign bus_lo.out_ready = out_ready;

  // External Mealy detectors: last four bits since reset plus the bit on the wire.
  logic [3:0] dh_hi, dh_lo;
  always_ff @(posedge clk) begin
    if (!bus_hi.det_reset_n) dh_hi <= '0;
    else                     dh_hi <= {dh_hi[2:0], bus_hi.det_d_in};
    if (!bus_lo.det_reset_n) dh_lo <= '0;
    else                     dh_lo <= {dh_lo[2:0], bus_lo.det_d_in};
  end
  assign bus_hi.det_q_out = bus_hi.det_reset_n & ({dh_hi, bus_hi.det_d_in} == 5'b10101);
  assign bus_lo.det_q_out = bus_lo.det_reset_n & ({dh_lo, bus_lo.det_d_in} == 5'b10101);

  typedef struct { int raw; int first; } exp_t;

  exp_t        exp_q[$];
  bit          hist_q[$];
  int          checks = 0, failures = 0;
  int          cyc_n = 0, last_acc = 0, ov_rise = 0, drains = 0;
  bit          have_prev = 0, acc_seen = 0, hold_armed = 0, prev_ov = 0;
  logic [12:0] held;
  int          last_hit, last_cnt, last_first, last_sat_cnt;
`ifdef SCAN_OVF_FLAG_EN
  int          last_sat_ovf;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Observe one cycle after inputs settle: hold rule, drains against the model, accepts into the model.
  task automatic sample();
    exp_t e;
    int   raw, first;
    bit   cont;
    cyc_n++;
    acc_seen = 0;
    if (hold_armed) begin
      check("hold_valid", 64'(bus_hi.out_valid), 64'd1);
      check("hold_payload", 64'({bus_hi.out_hit, bus_hi.out_count, bus_hi.out_first}), 64'(held));
    end
    if (reset) begin
      exp_q.delete();
      hist_q.delete();
      have_prev  = 0;
      hold_armed = 0;
      prev_ov    = 0;
      return;
    end
    if (bus_hi.out_valid && !prev_ov) ov_rise = cyc_n;
    prev_ov = bus_hi.out_valid;
    if (bus_hi.out_valid && out_ready) begin
      drains++;
      last_hit     = int'(bus_hi.out_hit);
      last_cnt     = int'(bus_hi.out_count);
      last_first   = int'(bus_hi.out_first);
      last_sat_cnt = int'(bus_lo.out_count);
      if (exp_q.size() == 0) begin
        check("spurious_result", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("hit", 64'(bus_hi.out_hit), 64'(e.raw > 0));
        check("count", 64'(bus_hi.out_count), 64'(e.raw > MAX_HI ? MAX_HI : e.raw));
        check("first", 64'(bus_hi.out_first), 64'(e.first));
        check("sat_valid", 64'(bus_lo.out_valid), 64'd1);
        check("sat_count", 64'(bus_lo.out_count), 64'(e.raw > MAX_LO ? MAX_LO : e.raw));
`ifdef SCAN_OVF_FLAG_EN
        last_sat_ovf = int'(bus_lo.out_ovf);
        check("ovf", 64'(bus_hi.out_ovf), 64'(e.raw > MAX_HI));
        check("sat_ovf", 64'(bus_lo.out_ovf), 64'(e.raw > MAX_LO));
`endif
      end
    end
    if (in_valid && bus_hi.in_ready) begin
      if (have_prev) check("accept_gap_ok", 64'((cyc_n - last_acc) >= int'(WORD_W)), 64'd1);
      cont = have_prev && ((cyc_n - last_acc) == int'(WORD_W));
      if (!cont) hist_q.delete();
      raw   = 0;
      first = 0;
      for (int i = 0; i < int'(WORD_W); i++) begin
        hist_q.push_back(in_word[int'(WORD_W) - 1 - i]);
        if (hist_q.size() > 5) void'(hist_q.pop_front());
        if (hist_q.size() == 5 &&
            {hist_q[0], hist_q[1], hist_q[2], hist_q[3], hist_q[4]} == 5'b10101) begin
          if (raw == 0) first = i;
          raw++;
        end
      end
      exp_q.push_back('{raw, first});
      last_acc  = cyc_n;
      have_prev = 1;
      acc_seen  = 1;
    end
    hold_armed = bus_hi.out_valid && !out_ready;
    held       = {bus_hi.out_hit, bus_hi.out_count, bus_hi.out_first};
  endtask

  task automatic tick(input logic v, input logic [WORD_W-1:0] w, input logic r);
    @(negedge clk);
    reset     = rst_req;
    in_valid  = v;
    in_word   = w;
    out_ready = r;
    #1;
    sample();
  endtask

  task automatic offer(input logic [WORD_W-1:0] w, input logic r);
    tick(1'b1, w, r);
    for (int n = 0; n < 60 && !acc_seen; n++) tick(1'b1, w, r);
    check("accept_timeout", 64'(acc_seen), 64'd1);
  endtask

  task automatic wait_drains(input int target);
    for (int n = 0; n < 60 && drains < target; n++) tick(1'b0, '0, 1'b1);
    check("drain_timeout", 64'(drains >= target), 64'd1);
  endtask

  function automatic logic [WORD_W-1:0] pick_word();
    logic [WORD_W-1:0] pats [8] = '{16'hAAAA, 16'h5555, 16'hA800, 16'h000A,
                                    16'h8000, 16'hAA80, 16'hD555, 16'h0015};
    case ($urandom_range(0, 3))
      0:       return WORD_W'($urandom);
      1:       return pats[$urandom_range(0, 7)];
      2:       return 16'hAAAA ^ (16'h0001 << $urandom_range(0, 15));
      default: return 16'h5555 >> $urandom_range(0, 3);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int               d0, t0;
    logic             rv;
    logic [WORD_W-1:0] rw;

    repeat (3) tick(1'b0, '0, 1'b0);
    rst_req = 1'b0;
    tick(1'b0, '0, 1'b1);
    check("rst_out_valid", 64'(bus_hi.out_valid), 64'd0);
    check("rst_out_hit", 64'(bus_hi.out_hit), 64'd0);
    check("rst_out_count", 64'(bus_hi.out_count), 64'd0);
    check("rst_out_first", 64'(bus_hi.out_first), 64'd0);
    check("rst_det_d_in", 64'(bus_hi.det_d_in), 64'd0);
    check("rst_det_reset_n", 64'(bus_hi.det_reset_n), 64'd0);
    check("rst_in_ready", 64'(bus_hi.in_ready), 64'd1);

    // Single word, latency and mid-scan backpressure on the input side
    d0 = drains;
    offer(16'hA800, 1'b1);
    t0 = last_acc;
    tick(1'b0, '0, 1'b1);
    check("shift_in_ready", 64'(bus_hi.in_ready), 64'd0);
    check("shift_det_reset_n", 64'(bus_hi.det_reset_n), 64'd1);
    wait_drains(d0 + 1);
    check("t1_latency", 64'(ov_rise - t0), 64'd17);
    check("t1_hit", 64'(last_hit), 64'd1);
    check("t1_count", 64'(last_cnt), 64'd1);
    check("t1_first", 64'(last_first), 64'd4);

    // Overlapping matches
    d0 = drains;
    offer(16'hAA80, 1'b1);
    wait_drains(d0 + 1);
    check("t2_count", 64'(last_cnt), 64'd3);
    check("t2_first", 64'(last_first), 64'd4);

    // Back-to-back words keep detector context
    d0 = drains;
    offer(16'h000A, 1'b1);
    t0 = last_acc;
    offer(16'h8000, 1'b1);
    check("t3_b2b_gap", 64'(last_acc - t0), 64'd16);
    wait_drains(d0 + 2);
    check("t3_b2b_hit", 64'(last_hit), 64'd1);
    check("t3_b2b_count", 64'(last_cnt), 64'd1);
    check("t3_b2b_first", 64'(last_first), 64'd0);

    // One idle cycle between the same words restarts detection
    d0 = drains;
    offer(16'h000A, 1'b1);
    repeat (16) tick(1'b0, '0, 1'b1);
    offer(16'h8000, 1'b1);
    wait_drains(d0 + 2);
    check("t3_gap_count", 64'(last_cnt), 64'd0);
    check("t3_gap_hit", 64'(last_hit), 64'd0);

    // Result slot full: second result parks until the first drains
    d0 = drains;
    offer(16'hA800, 1'b0);
    offer(16'hAA80, 1'b0);
    repeat (24) tick(1'b0, '0, 1'b0);
    check("t4_wait_in_ready", 64'(bus_hi.in_ready), 64'd0);
    check("t4_wait_valid", 64'(bus_hi.out_valid), 64'd1);
    check("t4_wait_count", 64'(bus_hi.out_count), 64'd1);
    check("t4_wait_first", 64'(bus_hi.out_first), 64'd4);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b0);
    check("t4_second_valid", 64'(bus_hi.out_valid), 64'd1);
    check("t4_second_count", 64'(bus_hi.out_count), 64'd3);
    check("t4_idle_in_ready", 64'(bus_hi.in_ready), 64'd1);
    tick(1'b0, '0, 1'b1);
    check("t4_drained", 64'(drains - d0), 64'd2);

    // No matches at all
    d0 = drains;
    offer(16'hFFFF, 1'b1);
    wait_drains(d0 + 1);
    check("t5_hit", 64'(last_hit), 64'd0);
    check("t5_count", 64'(last_cnt), 64'd0);
    check("t5_first", 64'(last_first), 64'd0);

    // Reset while bit 7 is on the wire drops the word
    d0 = drains;
    offer(16'hA800, 1'b1);
    repeat (7) tick(1'b0, '0, 1'b1);
    rst_req = 1'b1;
    tick(1'b0, '0, 1'b1);
    rst_req = 1'b0;
    tick(1'b0, '0, 1'b1);
    check("t5_rst_out_valid", 64'(bus_hi.out_valid), 64'd0);
    check("t5_rst_det_reset_n", 64'(bus_hi.det_reset_n), 64'd0);
    check("t5_rst_in_ready", 64'(bus_hi.in_ready), 64'd1);
    repeat (30) tick(1'b0, '0, 1'b1);
    check("t5_no_result", 64'(drains - d0), 64'd0);

    // Six matches saturate the narrow counter
    d0 = drains;
    offer(16'hAAAA, 1'b1);
    wait_drains(d0 + 1);
    check("t6_count", 64'(last_cnt), 64'd6);
    check("t6_sat_count", 64'(last_sat_cnt), 64'd3);
`ifdef SCAN_OVF_FLAG_EN
    check("t6_sat_ovf", 64'(last_sat_ovf), 64'd1);
`endif

    // Random traffic with random backpressure and rare resets
    rv = 1'b0;
    rw = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!rv || acc_seen) begin
        rv = ($urandom_range(0, 9) < 6);
        rw = pick_word();
      end
      rst_req = ($urandom_range(0, 599) == 0);
      tick(rv, rw, ($urandom_range(0, 9) < 6));
    end
    rst_req = 1'b0;
    repeat (60) tick(1'b0, '0, 1'b1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
